micro_store: RTL
================

Name: micro_store

Overview:
- Memory-mapped microcode backing store for the soc_demo peripheral bus.
- Holds the shadow GPR file, a temp-variable scratch bank, a constant table, the RZ register and the micro-procedure store.
- Parametrised successor of the fixed-size store.
  - Region sizes and bases are configurable.
  - Uses a split request/response handshake instead of a tri-state data bus.
  - Supports byte-enabled writes and reports faults.
  - Runs a hardware clear sequencer after reset or on demand.

Parameters:
- NUM_GPR, 32, number of GPR words; entry 0 is hardwired to zero.
- NUM_TMP, 32, number of temp words; every word in the region is backed.
- PRC_DEPTH, 1024, procedure-store depth in words; power of two.
- GPR_BASE, 32'hffffc000, GPR region base.
- TMP_BASE, 32'hffffc080, temp region base.
- CON_BASE, 32'hffffc100, constant region base; 64 words, read-only.
- RZ_ADDR, 32'hffffc200, RZ register address.
- PRC_BASE, 32'hffffe000, procedure region base.
- INIT_FILE, "", hex file preloaded into the procedure store; empty means no preload.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request can be accepted.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, write data.
- req_be, in, 4, byte enables for writes.
- rsp_valid, out, 1, one-cycle response strobe.
- rsp_rdata, out, 32, read data; 0 for writes and faults.
- rsp_fault, out, 1, request rejected.
- clr_req, in, 1, pulse: restart the clear sequence.
- busy, out, 1, clear sequence in progress.

Behaviour:
- Reset (rst high at clk edge):
  - State goes to CLEAR and the clear counter to 0.
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0, busy=1, RZ=0.
  - Any response still pending is dropped.
  - The procedure store is not touched by reset.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to GPR[cnt] (if cnt<NUM_GPR) and TMP[cnt] (if cnt<NUM_TMP), then increments cnt.
  - When cnt reaches max(NUM_GPR,NUM_TMP)-1, it moves to IDLE on the next edge.
  - req_ready=0 and busy=1 throughout.
  - Reset during CLEAR restarts cnt at 0.
- IDLE:
  - busy=0.
  - req_ready = ~clr_req (the only combinational path).
  - clr_req in IDLE clears RZ and moves to CLEAR with cnt=0; the request on that cycle is not accepted.
- Accept occurs on req_valid & req_ready. At most one request is accepted per cycle.
- Response timing:
  - The response registers on the edge after accept, so rsp_valid is high exactly the following cycle.
  - Read latency is 1 cycle.
  - Back-to-back accepts give back-to-back responses.
- Decode (word index = (addr-base)>>2):
  - GPR: GPR_BASE .. +4*NUM_GPR-1.
  - TMP: TMP_BASE .. +4*NUM_TMP-1.
  - CON: CON_BASE .. +255.
  - RZ: exactly RZ_ADDR.
  - PRC: PRC_BASE .. +4*PRC_DEPTH-1.
- Fault conditions (rsp_fault=1, rsp_rdata=0, no state change):
  - addr[1:0]!=0;
  - address in no region;
  - write to CON.
- GPR index 0:
  - Writes are silently ignored with no fault.
  - Reads return 0.
- Writes: each byte i is updated only when req_be[i]=1. req_be=0 is a legal no-op write with no fault.
- Constants:
  - Index k<32 gives 1<<k.
  - Index 32..63 gives (1<<(k-32))-1, so index 32 = 0 and index 63 = 32'h7fffffff.
- Ordering: a read accepted the cycle after a write to the same address returns the new data; there is no hazard window.
- The procedure store is preloaded from INIT_FILE at elaboration. It is retained across rst and clr_req.

Decomposition:
- Package micro_store_pkg holds:
  - the default region base constants;
  - the region enum (REG_NONE, REG_GPR, REG_TMP, REG_CON, REG_RZ, REG_PRC);
  - the FSM state enum;
  - the constant-table function.
- Sub-module micro_store_decode: purely combinational. Maps addr to {region, word index, misaligned}. It is shared by the response path and the testbench model.

Test Plan:
- Reset: rst=1 for 1 cycle, NUM_GPR=NUM_TMP=32 -> busy=1 and req_ready=0 for exactly 32 cycles, then ready=1. A read of 0xffffc014 then returns 0 with fault=0.
- Byte-enabled write:
  - Write 0xffffc00c = 32'hDEADBEEF with be=F, then read -> 32'hDEADBEEF, rsp_valid one cycle after accept.
  - Write 32'h000000AA with be=4'b0001 -> read gives 32'hDEADBEAA.
- GPR0 and RZ:
  - Write 0xffffc000 = 32'h1234 -> fault=0; a read returns 0.
  - Write RZ 32'h5 then read 0xffffc200 -> 32'h5.
- Constants:
  - Read 0xffffc100+4*40 -> 32'h000000FF.
  - Read 0xffffc100+4*3 -> 32'h8.
  - Write 0xffffc104 -> fault=1; a subsequent read still returns 32'h2.
- Faults: read 0xffffc204 -> fault=1, rdata=0; read 0xffffc001 -> fault=1; a request held during CLEAR is accepted only after busy falls.
- Clear:
  - Write TMP[7]=32'h77, PRC[5]=32'hCAFE, then pulse clr_req -> busy high for 32 cycles.
  - TMP[7] then reads 0 and PRC[5] still reads 32'hCAFE.
  - Asserting rst at cnt=10 restarts a full 32-cycle clear.

Source files
------------

// File: rtl/micro_store_pkg.sv
// micro_store shared types: region/state enums, default bases,
// constant table and byte-merge helpers.
package micro_store_pkg;

  localparam logic [31:0] DEF_GPR_BASE = 32'hffffc000;
  localparam logic [31:0] DEF_TMP_BASE = 32'hffffc080;
  localparam logic [31:0] DEF_CON_BASE = 32'hffffc100;
  localparam logic [31:0] DEF_RZ_ADDR  = 32'hffffc200;
  localparam logic [31:0] DEF_PRC_BASE = 32'hffffe000;
  localparam int          CON_WORDS    = 64;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_GPR,
    REG_TMP,
    REG_CON,
    REG_RZ,
    REG_PRC
  } region_e;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  // Lower half: single-bit masks; upper half: low-ones masks.
  function automatic logic [31:0] con_word(input logic [5:0] k);
    logic [31:0] one_hot;
    one_hot = 32'h1 << k[4:0];
    return k[5] ? one_hot - 32'h1 : one_hot;
  endfunction

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/micro_store_decode.sv
// micro_store address decoder: byte address to region,
// word index and misalignment flag.
module micro_store_decode
  import micro_store_pkg::*;
#(
  parameter int          NUM_GPR   = 32,
  parameter int          NUM_TMP   = 32,
  parameter int          PRC_DEPTH = 1024,
  parameter logic [31:0] GPR_BASE  = DEF_GPR_BASE,
  parameter logic [31:0] TMP_BASE  = DEF_TMP_BASE,
  parameter logic [31:0] CON_BASE  = DEF_CON_BASE,
  parameter logic [31:0] RZ_ADDR   = DEF_RZ_ADDR,
  parameter logic [31:0] PRC_BASE  = DEF_PRC_BASE,
  parameter int          IW        = 10
) (
  input  logic [31:0]   addr,
  output region_e       region,
  output logic [IW-1:0] idx,
  output logic          misaligned
);

  logic in_gpr;
  logic in_tmp;
  logic in_con;
  logic in_rz;
  logic in_prc;

  // Unsigned wrap makes addr < base fall out of range too.
  assign in_gpr = (addr - GPR_BASE) < 32'(4 * NUM_GPR);
  assign in_tmp = (addr - TMP_BASE) < 32'(4 * NUM_TMP);
  assign in_con = (addr - CON_BASE) < 32'(4 * CON_WORDS);
  assign in_rz  = addr == RZ_ADDR;
  assign in_prc = (addr - PRC_BASE) < 32'(4 * PRC_DEPTH);

  assign misaligned = |addr[1:0];

  always_comb begin
    region = REG_NONE;
    idx    = '0;
    unique case (1'b1)
      in_gpr: begin
        region = REG_GPR;
        idx    = IW'((addr - GPR_BASE) >> 2);
      end
      in_tmp: begin
        region = REG_TMP;
        idx    = IW'((addr - TMP_BASE) >> 2);
      end
      in_con: begin
        region = REG_CON;
        idx    = IW'((addr - CON_BASE) >> 2);
      end
      in_rz: begin
        region = REG_RZ;
      end
      in_prc: begin
        region = REG_PRC;
        idx    = IW'((addr - PRC_BASE) >> 2);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_store.sv
// micro_store: memory-mapped microcode backing store with
// request/response bus, byte enables, faults and clear sequencer.
module micro_store
  import micro_store_pkg::*;
#(
  parameter int          NUM_GPR   = 32,
  parameter int          NUM_TMP   = 32,
  parameter int          PRC_DEPTH = 1024,
  parameter logic [31:0] GPR_BASE  = DEF_GPR_BASE,
  parameter logic [31:0] TMP_BASE  = DEF_TMP_BASE,
  parameter logic [31:0] CON_BASE  = DEF_CON_BASE,
  parameter logic [31:0] RZ_ADDR   = DEF_RZ_ADDR,
  parameter logic [31:0] PRC_BASE  = DEF_PRC_BASE,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  input  logic        clr_req,
  output logic        busy
);

  localparam int CLR_N = (NUM_GPR > NUM_TMP) ? NUM_GPR : NUM_TMP;
  localparam int CW    = (CLR_N > 1) ? $clog2(CLR_N) : 1;
  localparam int GW    = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
  localparam int TW    = (NUM_TMP > 1) ? $clog2(NUM_TMP) : 1;
  localparam int PW    = (PRC_DEPTH > 1) ? $clog2(PRC_DEPTH) : 1;
  localparam int IW0   = (PW > 6) ? PW : 6;
  localparam int IW1   = (GW > IW0) ? GW : IW0;
  localparam int IW    = (TW > IW1) ? TW : IW1;
  localparam logic [CW-1:0] LAST = CW'(CLR_N - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clr_we;

  region_e       region;
  logic [IW-1:0] idx;
  logic          misaligned;
  logic [GW-1:0] gi;
  logic [TW-1:0] ti;
  logic [PW-1:0] pi;

  logic          acc;
  logic          fault;
  logic          wr_ok;
  logic [31:0]   rd_data;

  logic [31:0]   gpr [NUM_GPR];
  logic [31:0]   tmp [NUM_TMP];
  logic [31:0]   prc [PRC_DEPTH];
  logic [31:0]   rz_q;

  micro_store_decode #(
    .NUM_GPR   (NUM_GPR),
    .NUM_TMP   (NUM_TMP),
    .PRC_DEPTH (PRC_DEPTH),
    .GPR_BASE  (GPR_BASE),
    .TMP_BASE  (TMP_BASE),
    .CON_BASE  (CON_BASE),
    .RZ_ADDR   (RZ_ADDR),
    .PRC_BASE  (PRC_BASE),
    .IW        (IW)
  ) u_dec (
    .addr       (req_addr),
    .region     (region),
    .idx        (idx),
    .misaligned (misaligned)
  );

  assign gi = idx[GW-1:0];
  assign ti = idx[TW-1:0];
  assign pi = idx[PW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    req_ready = 1'b0;
    clr_we    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        req_ready = ~clr_req;
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign acc   = req_valid & req_ready;
  assign fault = misaligned | (region == REG_NONE)
               | (req_we & (region == REG_CON));
  assign wr_ok = acc & req_we & ~fault & ~rst;

  always_comb begin
    rd_data = '0;
    unique case (region)
      REG_GPR: rd_data = (gi == '0) ? '0 : gpr[gi];
      REG_TMP: rd_data = tmp[ti];
      REG_CON: rd_data = con_word(idx[5:0]);
      REG_RZ:  rd_data = rz_q;
      REG_PRC: rd_data = prc[pi];
      default: rd_data = '0;
    endcase
  end

  // GPR[0] is never written by the bus; reads mask it anyway.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      if (32'(cnt_q) < NUM_GPR) gpr[cnt_q[GW-1:0]] <= '0;
      if (32'(cnt_q) < NUM_TMP) tmp[cnt_q[TW-1:0]] <= '0;
    end else if (wr_ok) begin
      if (region == REG_GPR && gi != '0)
        gpr[gi] <= be_merge(gpr[gi], req_wdata, req_be);
      if (region == REG_TMP)
        tmp[ti] <= be_merge(tmp[ti], req_wdata, req_be);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && region == REG_PRC)
      prc[pi] <= be_merge(prc[pi], req_wdata, req_be);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rz_q <= '0;
    end else if (state_q == IDLE && clr_req) begin
      rz_q <= '0;
    end else if (wr_ok && region == REG_RZ) begin
      rz_q <= be_merge(rz_q, req_wdata, req_be);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= acc;
      rsp_fault <= acc & fault;
      rsp_rdata <= (acc & ~fault & ~req_we) ? rd_data : '0;
    end
  end

endmodule
